// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: widths, opcodes,
// FSM states and the six-bit {zx,nx,zy,ny,f,no} control words.
package alu_arb_pkg;

  localparam int DW_DEF  = 16;
  localparam int OPW_DEF = 5;
  localparam int CW_DEF  = 16;

  localparam int OP_ZERO = 0;
  localparam int OP_ONE  = 1;
  localparam int OP_NEG1 = 2;
  localparam int OP_X    = 3;
  localparam int OP_Y    = 4;
  localparam int OP_NOTX = 5;
  localparam int OP_NOTY = 6;
  localparam int OP_NEGX = 7;
  localparam int OP_NEGY = 8;
  localparam int OP_XP1  = 9;
  localparam int OP_YP1  = 10;
  localparam int OP_XM1  = 11;
  localparam int OP_YM1  = 12;
  localparam int OP_ADD  = 13;
  localparam int OP_XMY  = 14;
  localparam int OP_YMX  = 15;
  localparam int OP_AND  = 16;
  localparam int OP_OR   = 17;

  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ONE  = 6'b111111;
  localparam logic [5:0] CTL_NEG1 = 6'b111010;
  localparam logic [5:0] CTL_X    = 6'b001100;
  localparam logic [5:0] CTL_Y    = 6'b110000;
  localparam logic [5:0] CTL_NOTX = 6'b001101;
  localparam logic [5:0] CTL_NOTY = 6'b110001;
  localparam logic [5:0] CTL_NEGX = 6'b001111;
  localparam logic [5:0] CTL_NEGY = 6'b110011;
  localparam logic [5:0] CTL_XP1  = 6'b011111;
  localparam logic [5:0] CTL_YP1  = 6'b110111;
  localparam logic [5:0] CTL_XM1  = 6'b001110;
  localparam logic [5:0] CTL_YM1  = 6'b110010;
  localparam logic [5:0] CTL_ADD  = 6'b000010;
  localparam logic [5:0] CTL_XMY  = 6'b010011;
  localparam logic [5:0] CTL_YMX  = 6'b000111;
  localparam logic [5:0] CTL_AND  = 6'b000000;
  localparam logic [5:0] CTL_OR   = 6'b010101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode to the ALU control word; unknown opcodes
// produce the "zero" control word and raise err.
module alu_op_decode
  import alu_arb_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] op,
  output logic [5:0]     ctl,
  output logic           err
);

  always_comb begin
    ctl = CTL_ZERO;
    err = 1'b0;
    case (int'(op))
      OP_ZERO: ctl = CTL_ZERO;
      OP_ONE:  ctl = CTL_ONE;
      OP_NEG1: ctl = CTL_NEG1;
      OP_X:    ctl = CTL_X;
      OP_Y:    ctl = CTL_Y;
      OP_NOTX: ctl = CTL_NOTX;
      OP_NOTY: ctl = CTL_NOTY;
      OP_NEGX: ctl = CTL_NEGX;
      OP_NEGY: ctl = CTL_NEGY;
      OP_XP1:  ctl = CTL_XP1;
      OP_YP1:  ctl = CTL_YP1;
      OP_XM1:  ctl = CTL_XM1;
      OP_YM1:  ctl = CTL_YM1;
      OP_ADD:  ctl = CTL_ADD;
      OP_XMY:  ctl = CTL_XMY;
      OP_YMX:  ctl = CTL_YMX;
      OP_AND:  ctl = CTL_AND;
      OP_OR:   ctl = CTL_OR;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external ALU between two valid/ready requesters,
// with a single registered response channel. Define ALU_ARB_STATS_EN to add
// per-requester saturating accept counters.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
`ifdef ALU_ARB_STATS_EN
  , parameter int CW = CW_DEF
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_x,
  input  logic [DW-1:0]  req0_y,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_x,
  input  logic [DW-1:0]  req1_y,
  output logic [DW-1:0]  alu_x,
  output logic [DW-1:0]  alu_y,
  output logic [5:0]     alu_ctl,
  input  logic [DW-1:0]  alu_o,
  input  logic           alu_zr,
  input  logic           alu_ng,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_zr,
  output logic           rsp_ng,
  output logic           rsp_err
`ifdef ALU_ARB_STATS_EN
  , output logic [CW-1:0] stat0_cnt
  , output logic [CW-1:0] stat1_cnt
`endif
);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [DW-1:0]  alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [5:0]     alu_ctl_q, alu_ctl_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_zr_q, rsp_zr_d, rsp_ng_q, rsp_ng_d, rsp_err_q, rsp_err_d;
  logic           rsp_id_q, rsp_id_d;

  logic           gnt_id, accept;
  logic [OPW-1:0] sel_op;
  logic [DW-1:0]  sel_x, sel_y;
  logic [5:0]     dec_ctl;
  logic           dec_err;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
    req1_ready = (state_q == IDLE) && req1_valid && gnt_id;
    accept     = req0_ready || req1_ready;
    sel_op     = gnt_id ? req1_op : req0_op;
    sel_x      = gnt_id ? req1_x  : req0_x;
    sel_y      = gnt_id ? req1_y  : req0_y;
  end

  alu_op_decode #(.OPW(OPW)) u_dec (
    .op  (sel_op),
    .ctl (dec_ctl),
    .err (dec_err)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_ctl_d    = alu_ctl_q;
    err_d        = err_q;
    rsp_data_d   = rsp_data_q;
    rsp_zr_d     = rsp_zr_q;
    rsp_ng_d     = rsp_ng_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: if (accept) begin
        alu_x_d      = sel_x;
        alu_y_d      = sel_y;
        alu_ctl_d    = dec_ctl;
        err_d        = dec_err;
        last_grant_d = gnt_id;
        state_d      = EXEC;
      end
      EXEC: begin
        // last_grant_q already names the requester being served.
        rsp_id_d   = last_grant_q;
        rsp_data_d = err_q ? '0 : alu_o;
        rsp_zr_d   = err_q | alu_zr;
        rsp_ng_d   = ~err_q & alu_ng;
        rsp_err_d  = err_q;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_ctl_q    <= '0;
      err_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zr_q     <= 1'b0;
      rsp_ng_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_ctl_q    <= alu_ctl_d;
      err_q        <= err_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zr_q     <= rsp_zr_d;
      rsp_ng_q     <= rsp_ng_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_ctl   = alu_ctl_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] stat0_q, stat0_d, stat1_q, stat1_d;

  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (req0_ready && !(&stat0_q)) stat0_d = stat0_q + 1'b1;
    if (req1_ready && !(&stat1_q)) stat1_d = stat1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the
// external six-control-bit ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [15:0] alu_x, alu_y, alu_o;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zr, rsp_ng, rsp_err;
  logic [15:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat0_cnt, stat1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
    .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
    , .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
`endif
  );

  // External ALU: {zx,nx,zy,ny,f,no}
  logic [15:0] ax, ay;
  always_comb begin
    ax = alu_ctl[5] ? 16'h0 : alu_x;
    ax = alu_ctl[4] ? ~ax : ax;
    ay = alu_ctl[3] ? 16'h0 : alu_y;
    ay = alu_ctl[2] ? ~ay : ay;
    alu_o = alu_ctl[1] ? ax + ay : ax & ay;
    alu_o = alu_ctl[0] ? ~alu_o : alu_o;
    alu_zr = (alu_o == 16'h0);
    alu_ng = alu_o[15];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One op end-to-end with rsp_ready held high: accept, EXEC, RESP, IDLE.
  task automatic run_op(input string tag, input logic sel, input logic [4:0] op,
                        input logic [15:0] x, input logic [15:0] y, input logic [5:0] ctl,
                        input logic [15:0] d, input logic zr, input logic ng, input logic err);
    @(negedge clk);
    if (sel) begin req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y; end
    else     begin req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y; end
    #1;
    chk({tag, "_rdy"}, sel ? req1_ready : req0_ready, 1);
    chk({tag, "_rdy_other"}, sel ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_vld"}, rsp_valid, 0);
    chk({tag, "_ctl"}, alu_ctl, ctl);
    chk({tag, "_alu_x"}, alu_x, x);
    chk({tag, "_alu_y"}, alu_y, y);
    @(negedge clk);
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_flags"}, {rsp_zr, rsp_ng, rsp_err, rsp_id}, {zr, ng, err, sel});
    @(negedge clk);
    chk({tag, "_idle"}, rsp_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_vld", rsp_valid, 0);
    chk("rst_alu", {alu_x, alu_y, alu_ctl}, 0);
    chk("rst_rsp", {rsp_data, rsp_zr, rsp_ng, rsp_err, rsp_id}, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add",  1'b0, 5'd13, 16'd3,   16'd4,   6'b000010, 16'h0007, 0, 0, 0);
    run_op("xmy",  1'b1, 5'd14, 16'd2,   16'd5,   6'b010011, 16'hFFFD, 0, 1, 0);
    run_op("zero", 1'b0, 5'd0,  16'd7,   16'd9,   6'b101010, 16'h0000, 1, 0, 0);
    run_op("or",   1'b1, 5'd17, 16'h8001, 16'h0100, 6'b010101, 16'h8101, 0, 1, 0);
    run_op("bad",  1'b0, 5'd20, 16'h1234, 16'h5678, 6'b101010, 16'h0000, 1, 0, 1);

    // Tie after reset: req0, then req1, then req0 again; stall the first response.
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 5'd9;  req0_x = 16'd5;    req0_y = 16'd0;
    req1_valid = 1'b1; req1_op = 5'd16; req1_x = 16'hF0F0; req1_y = 16'h0FF0;
    #1;
    chk("tie1_rdy", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    chk("tie1_exec_rdy", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    chk("tie1_vld", rsp_valid, 1);
    chk("tie1_data", rsp_data, 16'h0006);
    chk("tie1_id", rsp_id, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {rsp_valid, rsp_data, rsp_id, rsp_err}, {1'b1, 16'h0006, 1'b0, 1'b0});
      chk("stall_rdy", {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("tie2_idle", rsp_valid, 0);
    chk("tie2_rdy", {req0_ready, req1_ready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("tie2_data", {rsp_valid, rsp_data, rsp_id}, {1'b1, 16'h00F0, 1'b1});
    @(negedge clk);
    chk("tie3_rdy", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("drop_rdy", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("drop_no_op", rsp_valid, 0);

    // Reset while EXEC: op is dropped, then a req1 op completes normally.
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 5'd13; req1_x = 16'd1; req1_y = 16'd1;
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", rsp_valid, 0);
    chk("mid_rst_ctl", alu_ctl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_quiet", rsp_valid, 0);
    @(negedge clk);
    chk("mid_rst_quiet2", rsp_valid, 0);
    run_op("post_rst", 1'b1, 5'd13, 16'd2, 16'd3, 6'b000010, 16'h0005, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
